pulse_scheduler: RTL and testbench

Multi-channel pulse scheduler that shares one clock-divider/phase timebase among `CHANNELS` pulse-width outputs. It accepts per-channel width writes over a valid/ready port and applies each new width only at that channel's frame boundary, so no pulse is ever truncated or stretched mid-period. Channel phases are staggered so that rising edges are spread across the frame. An optional ramp mode slews each width by one step per frame. It sits between the host register interface and the off-chip pulse pins.

---
 rtl/pulse_scheduler_if.sv | 27 ++
 rtl/pulse_scheduler.sv | 136 +++++++++++++
 tb/tb_pulse_scheduler.sv | 320 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pulse_scheduler_if.sv
// Host configuration port of the pulse scheduler: a valid/ready write
// channel carrying a target channel, a width and a ramp flag.
interface pulse_scheduler_if #(
    parameter int CHAN_BITS = 2
);
    logic                 CFG_VALID;
    logic                 CFG_READY;
    logic [CHAN_BITS-1:0] CFG_CHAN;
    logic [3:0]           CFG_WIDTH;
    logic                 CFG_RAMP;

    modport master (
        output CFG_VALID,
        output CFG_CHAN,
        output CFG_WIDTH,
        output CFG_RAMP,
        input  CFG_READY
    );

    modport slave (
        input  CFG_VALID,
        input  CFG_CHAN,
        input  CFG_WIDTH,
        input  CFG_RAMP,
        output CFG_READY
    );
endinterface

// File: rtl/pulse_scheduler.sv
// Multi-channel pulse scheduler. One divider/phase timebase is shared by all
// channels; each channel sees the phase shifted by its own offset so rising
// edges are spread across the 16-tick frame. Width writes are staged in a
// target register and only take effect at the channel's own frame boundary,
// optionally slewing one step per frame.
module pulse_scheduler #(
    parameter int CLOCK_DIVIDER = 50000,
    parameter int CHANNELS      = 4,
    parameter int CHAN_BITS     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                CLOCK,
    input  logic                RESET_N,
    pulse_scheduler_if.slave    cfg,
    output logic [CHANNELS-1:0] PULSE,
    output logic                FRAME
);

    localparam int                DIV_W      = $clog2(CLOCK_DIVIDER);
    localparam logic [DIV_W-1:0]  DIV_RELOAD = DIV_W'(CLOCK_DIVIDER - 1);
    localparam int                OFF_STEP   = 16 / CHANNELS;

    logic [DIV_W-1:0]    r_div_cnt;
    logic [3:0]          r_phase;
    logic                r_frame;
    logic                r_ready;
    logic [CHANNELS-1:0] r_pulse;
    logic [3:0]          r_target [CHANNELS];
    logic [3:0]          r_active [CHANNELS];
    logic [CHANNELS-1:0] r_ramp;

    logic                w_tick;
    logic                w_accept;
    logic [3:0]          w_phase_nxt;
    logic [3:0]          w_lp [CHANNELS];
    logic [CHANNELS-1:0] w_bound;
    logic [CHANNELS-1:0] w_wr_hit;
    logic [CHANNELS-1:0] w_pulse_nxt;
    logic [3:0]          w_active_nxt [CHANNELS];

    // One ramp step of the active width toward its target, holding when equal.
    function automatic logic [3:0] step_toward(input logic [3:0] cur, input logic [3:0] tgt);
        logic [3:0] res;
        if (cur < tgt) begin
            res = cur + 4'd1;
        end else if (cur > tgt) begin
            res = cur - 4'd1;
        end else begin
            res = cur;
        end
        return res;
    endfunction

    // Tick, handshake, per-channel local phase, boundary and next-state decode.
    always_comb begin
        w_tick      = (r_div_cnt == '0);
        w_accept    = cfg.CFG_VALID && r_ready;
        w_phase_nxt = r_phase + 4'd1;
        for (int i = 0; i < CHANNELS; i++) begin
            w_lp[i]        = r_phase - 4'(i * OFF_STEP);
            // Local phase about to wrap 15->0 means this tick is the channel's boundary.
            w_bound[i]     = w_tick && (w_lp[i] == 4'd15);
            w_wr_hit[i]    = w_accept && (cfg.CFG_CHAN == CHAN_BITS'(i));
            w_pulse_nxt[i] = (w_lp[i] < r_active[i]);
            if (w_bound[i]) begin
                if (r_ramp[i]) begin
                    w_active_nxt[i] = step_toward(r_active[i], r_target[i]);
                end else begin
                    w_active_nxt[i] = r_target[i];
                end
            end else begin
                w_active_nxt[i] = r_active[i];
            end
        end
    end

    // Clock divider, global phase counter and frame strobe.
    always_ff @(posedge CLOCK) begin
        if (!RESET_N) begin
            r_div_cnt <= DIV_RELOAD;
            r_phase   <= 4'd0;
            r_frame   <= 1'b0;
        end else begin
            if (w_tick) begin
                r_div_cnt <= DIV_RELOAD;
                r_phase   <= w_phase_nxt;
            end else begin
                r_div_cnt <= r_div_cnt - DIV_W'(1);
            end
            r_frame <= w_tick && (r_phase == 4'd15);
        end
    end

    // Ready drops for exactly one cycle after each accepted write.
    always_ff @(posedge CLOCK) begin
        if (!RESET_N) begin
            r_ready <= 1'b0;
        end else begin
            r_ready <= !w_accept;
        end
    end

    // Per-channel staged target/ramp and boundary-applied active width.
    always_ff @(posedge CLOCK) begin
        for (int i = 0; i < CHANNELS; i++) begin
            if (!RESET_N) begin
                r_target[i] <= 4'd0;
                r_active[i] <= 4'd0;
                r_ramp[i]   <= 1'b0;
            end else begin
                // Boundary reads the pre-write target, so a colliding write waits a frame.
                r_active[i] <= w_active_nxt[i];
                if (w_wr_hit[i]) begin
                    r_target[i] <= cfg.CFG_WIDTH;
                    r_ramp[i]   <= cfg.CFG_RAMP;
                end else begin
                    r_target[i] <= r_target[i];
                    r_ramp[i]   <= r_ramp[i];
                end
            end
        end
    end

    // Registered pulse outputs, one cycle behind the phase.
    always_ff @(posedge CLOCK) begin
        if (!RESET_N) begin
            r_pulse <= '0;
        end else begin
            r_pulse <= w_pulse_nxt;
        end
    end

    assign PULSE         = r_pulse;
    assign FRAME         = r_frame;
    assign cfg.CFG_READY = r_ready;

endmodule

// File: tb/tb_pulse_scheduler.sv
// Self-checking bench for pulse_scheduler: a frame-arithmetic reference model
// compared every cycle, plus directed frame-width measurements and random writes.
module tb_pulse_scheduler;

    localparam int D   = 4;
    localparam int NCH = 4;

    logic       CLOCK = 1'b0;
    logic       RESET_N;
    logic [3:0] pulse_a;
    logic       frame_a;
    logic [1:0] pulse_b;
    logic       frame_b;

    pulse_scheduler_if #(.CHAN_BITS(2)) cfg_a ();
    pulse_scheduler_if #(.CHAN_BITS(2)) cfg_b ();

    pulse_scheduler #(.CLOCK_DIVIDER(D), .CHANNELS(NCH)) u_dut_a (
        .CLOCK   (CLOCK),
        .RESET_N (RESET_N),
        .cfg     (cfg_a),
        .PULSE   (pulse_a),
        .FRAME   (frame_a)
    );

    pulse_scheduler #(.CLOCK_DIVIDER(D), .CHANNELS(2), .CHAN_BITS(2)) u_dut_b (
        .CLOCK   (CLOCK),
        .RESET_N (RESET_N),
        .cfg     (cfg_b),
        .PULSE   (pulse_b),
        .FRAME   (frame_b)
    );

    always #5 CLOCK = ~CLOCK;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state (channel offsets are 4*i ticks for 4 channels).
    int unsigned k;
    int          m_target [NCH];
    int          m_ramp   [NCH];
    int          m_active [NCH];
    logic [3:0]  m_pulse;
    logic        m_frame;
    logic        m_ready;
    logic        m_accepted;
    int          fc [NCH];

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int lp(input int ph, input int ch);
        return (ph - 4 * ch + 16) % 16;
    endfunction

    // Advance the model by one clock edge using the inputs sampled at that edge.
    task automatic model_step();
        int ph;
        int nph;
        bit tk;
        bit acc;
        if (!RESET_N) begin
            k = 0;
            for (int i = 0; i < NCH; i++) begin
                m_target[i] = 0;
                m_ramp[i]   = 0;
                m_active[i] = 0;
            end
            m_pulse    = 4'd0;
            m_frame    = 1'b0;
            m_ready    = 1'b0;
            m_accepted = 1'b0;
        end else begin
            ph  = (k / D) % 16;
            nph = ((k + 1) / D) % 16;
            tk  = ((k % D) == D - 1);
            acc = cfg_a.CFG_VALID && m_ready;
            for (int i = 0; i < NCH; i++) m_pulse[i] = (lp(ph, i) < m_active[i]);
            if (tk) begin
                for (int i = 0; i < NCH; i++) begin
                    if (nph == 4 * i) begin
                        if (m_ramp[i] == 0) m_active[i] = m_target[i];
                        else if (m_active[i] < m_target[i]) m_active[i]++;
                        else if (m_active[i] > m_target[i]) m_active[i]--;
                    end
                end
            end
            if (acc) begin
                m_target[int'(cfg_a.CFG_CHAN)] = int'(cfg_a.CFG_WIDTH);
                m_ramp[int'(cfg_a.CFG_CHAN)]   = int'(cfg_a.CFG_RAMP);
            end
            m_accepted = acc;
            m_ready    = !acc;
            m_frame    = tk && (nph == 0);
            k++;
        end
    endtask

    task automatic cycle();
        @(posedge CLOCK);
        model_step();
        @(negedge CLOCK);
        check_val("pulse", 32'(pulse_a), 32'(m_pulse));
        check_val("frame", 32'(frame_a), 32'(m_frame));
        check_val("ready", 32'(cfg_a.CFG_READY), 32'(m_ready));
    endtask

    task automatic do_write(input int ch, input int w, input int r);
        logic seen;
        seen = 1'b0;
        cfg_a.CFG_VALID = 1'b1;
        cfg_a.CFG_CHAN  = 2'(ch);
        cfg_a.CFG_WIDTH = 4'(w);
        cfg_a.CFG_RAMP  = 1'(r);
        for (int n = 0; n < 4 && !seen; n++) begin
            seen = cfg_a.CFG_READY;
            cycle();
        end
        cfg_a.CFG_VALID = 1'b0;
        check_val("wr_ready", 32'(seen), 32'd1);
    endtask

    // Count high cycles per channel up to and including the next FRAME strobe.
    task automatic frame_count();
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < NCH; i++) fc[i] = 0;
        for (int n = 0; n < 80 && !seen; n++) begin
            cycle();
            for (int i = 0; i < NCH; i++) fc[i] += int'(pulse_a[i]);
            seen = frame_a;
        end
        check_val("frame_wait", 32'(seen), 32'd1);
    endtask

    initial begin : main
        int f1, f2, acc_cnt, ovl, total;
        int rise [NCH];
        logic [3:0] prev;
        logic found;
        int exp_up [4];
        int exp_dn [3];

        RESET_N = 1'b0;
        cfg_a.CFG_VALID = 1'b0; cfg_a.CFG_CHAN = 2'd0; cfg_a.CFG_WIDTH = 4'd0; cfg_a.CFG_RAMP = 1'b0;
        cfg_b.CFG_VALID = 1'b0; cfg_b.CFG_CHAN = 2'd0; cfg_b.CFG_WIDTH = 4'd0; cfg_b.CFG_RAMP = 1'b0;

        // Reset held for 10 cycles
        repeat (10) cycle();
        check_val("rst_ready", 32'(cfg_a.CFG_READY), 32'd0);
        check_val("rst_pulse", 32'(pulse_a), 32'd0);
        RESET_N = 1'b1;
        cycle();
        check_val("ready_after_rel", 32'(cfg_a.CFG_READY), 32'd1);

        // Frame period
        f1 = -1; f2 = -1;
        for (int c = 0; c < 140; c++) begin
            cycle();
            if (frame_a) begin
                if (f1 < 0) f1 = c;
                else if (f2 < 0) f2 = c;
            end
        end
        check_val("frame_period", 32'(f2 - f1), 32'd64);

        // Jump write ch0 width 5
        do_write(0, 5, 0);
        frame_count();
        frame_count();
        check_val("jump_ch0", 32'(fc[0]), 32'd20);
        check_val("jump_others", 32'(fc[1] + fc[2] + fc[3]), 32'd0);

        // Stagger: width 4 on all channels
        for (int i = 0; i < NCH; i++) do_write(i, 4, 0);
        frame_count();
        frame_count();
        for (int i = 0; i < NCH; i++) rise[i] = -100;
        ovl = 0;
        prev = pulse_a;
        for (int c = 0; c < 64; c++) begin
            cycle();
            for (int i = 0; i < NCH; i++) if (pulse_a[i] && !prev[i]) rise[i] = c;
            if ($countones(pulse_a) > 1) ovl++;
            prev = pulse_a;
        end
        for (int i = 0; i < NCH - 1; i++)
            check_val("stagger_gap", 32'((rise[i + 1] - rise[i] + 128) % 64), 32'd16);
        check_val("stagger_overlap", 32'(ovl), 32'd0);

        // Ramp ch1 0 -> 3 -> 0
        do_write(1, 0, 0);
        frame_count();
        frame_count();
        exp_up = '{4, 8, 12, 12};
        exp_dn = '{8, 4, 0};
        do_write(1, 3, 1);
        for (int f = 0; f < 4; f++) begin
            frame_count();
            check_val("ramp_up", 32'(fc[1]), 32'(exp_up[f]));
        end
        do_write(1, 0, 1);
        for (int f = 0; f < 3; f++) begin
            frame_count();
            check_val("ramp_down", 32'(fc[1]), 32'(exp_dn[f]));
        end

        // Continuous valid: every 2nd cycle accepted
        acc_cnt = 0;
        cfg_a.CFG_VALID = 1'b1;
        for (int c = 0; c < 10; c++) begin
            cfg_a.CFG_CHAN  = 2'($urandom_range(3, 0));
            cfg_a.CFG_WIDTH = 4'($urandom_range(15, 0));
            cfg_a.CFG_RAMP  = 1'b0;
            if (cfg_a.CFG_READY) acc_cnt++;
            cycle();
        end
        cfg_a.CFG_VALID = 1'b0;
        check_val("b2b_accepts", 32'(acc_cnt), 32'd5);

        // Write colliding with ch0 boundary
        do_write(0, 5, 0);
        frame_count();
        frame_count();
        found = 1'b0;
        for (int n = 0; n < 80 && !found; n++) begin
            if (((k % D) == D - 1) && (((k / D) % 16) == 15)) found = 1'b1;
            else cycle();
        end
        check_val("coll_sync", 32'(found), 32'd1);
        cfg_a.CFG_VALID = 1'b1; cfg_a.CFG_CHAN = 2'd0; cfg_a.CFG_WIDTH = 4'd9; cfg_a.CFG_RAMP = 1'b0;
        cycle();
        cfg_a.CFG_VALID = 1'b0;
        check_val("coll_frame", 32'(frame_a), 32'd1);
        frame_count();
        check_val("coll_old", 32'(fc[0]), 32'd20);
        frame_count();
        check_val("coll_new", 32'(fc[0]), 32'd36);

        // Out-of-range channel on the 2-channel instance
        cfg_b.CFG_VALID = 1'b1; cfg_b.CFG_CHAN = 2'd2; cfg_b.CFG_WIDTH = 4'd15;
        cycle();
        cfg_b.CFG_VALID = 1'b0;
        cycle();
        cfg_b.CFG_VALID = 1'b1; cfg_b.CFG_CHAN = 2'd3;
        cycle();
        cfg_b.CFG_VALID = 1'b0;
        total = 0;
        for (int c = 0; c < 150; c++) begin
            cycle();
            total += $countones(pulse_b);
        end
        check_val("oor_no_pulse", 32'(total), 32'd0);
        cfg_b.CFG_VALID = 1'b1; cfg_b.CFG_CHAN = 2'd1; cfg_b.CFG_WIDTH = 4'd8;
        cycle();
        cfg_b.CFG_VALID = 1'b0;
        repeat (70) cycle();
        total = 0;
        for (int c = 0; c < 128; c++) begin
            cycle();
            total += int'(pulse_b[1]) + 2 * int'(pulse_b[0]);
        end
        check_val("b_ch1_width8", 32'(total), 32'd64);

        // Extremes
        do_write(0, 15, 0);
        frame_count();
        frame_count();
        frame_count();
        check_val("w15_high", 32'(fc[0]), 32'd60);
        do_write(0, 0, 0);
        frame_count();
        frame_count();
        frame_count();
        check_val("w0_high", 32'(fc[0]), 32'd0);

        // Reset mid-pulse
        do_write(0, 8, 0);
        frame_count();
        frame_count();
        found = 1'b0;
        for (int n = 0; n < 80 && !found; n++) begin
            cycle();
            found = pulse_a[0];
        end
        check_val("midrst_sync", 32'(found), 32'd1);
        RESET_N = 1'b0;
        cycle();
        check_val("midrst_pulse", 32'(pulse_a), 32'd0);
        repeat (3) cycle();
        RESET_N = 1'b1;
        total = 0;
        for (int c = 0; c < 150; c++) begin
            cycle();
            total += $countones(pulse_a);
        end
        check_val("midrst_cleared", 32'(total), 32'd0);

        // Random writes against the model
        for (int c = 0; c < 800; c++) begin
            cfg_a.CFG_VALID = ($urandom_range(2, 0) == 0);
            cfg_a.CFG_CHAN  = 2'($urandom_range(3, 0));
            cfg_a.CFG_WIDTH = 4'($urandom_range(15, 0));
            cfg_a.CFG_RAMP  = 1'($urandom_range(1, 0));
            cycle();
        end
        cfg_a.CFG_VALID = 1'b0;
        repeat (10) cycle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
